hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 id_rs1_s, id_rs2_s  in  5 each  source registers of the instruction in the ID stage.
REQ-004 ex_rd_s  in  5  destination register of the instruction in EX; ex_mem_read  in  1  EX instruction is a load; ex_regf_we  in  1  EX instruction writes the regfile.
REQ-005 br_taken  in  1  EX resolved a taken branch or jump.
REQ-006 imem_req  in  1  fetch issued this cycle; imem_resp  in  1  fetch data valid.
REQ-007 dmem_req  in  1  MEM load/store issued this cycle; dmem_resp  in  1  data access complete.
REQ-008 stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb  out  1 each  hold the named register.
REQ-009 bubble_id_ex  out  1  load a NOP into ID/EX; flush_if_id  out  1  load a NOP into IF/ID.
REQ-010 imem_discard  out  1  drop the current imem_resp.
REQ-011 stall_cnt, flush_cnt  out  32 each  performance counters.

Function
REQ-012 FSM states: RUN, I_WAIT, D_WAIT, ID_WAIT (both outstanding), I_KILL (fetch outstanding, result to be dropped).
REQ-013 Transitions:
- imem_req & !imem_resp -> fetch outstanding.
- dmem_req & !dmem_resp -> data outstanding.
- A matching resp clears the corresponding outstanding flag in the same cycle.
REQ-014 Data freeze, highest priority: when data is outstanding and dmem_resp is 0, or dmem_req & !dmem_resp, all five stall outputs are 1 and no bubble or flush is asserted.
REQ-015 Branch flush, second priority: br_taken with no data freeze -> flush_if_id=1 and bubble_id_ex=1 for exactly that cycle; stall_pc=0 so the redirect loads.
REQ-016 Branch while a fetch is outstanding -> next state I_KILL; the matching imem_resp asserts imem_discard=1, then the FSM returns to RUN.
REQ-017 Fetch wait, third priority: fetch outstanding without a resp -> stall_pc=1, stall_if_id=1, bubble_id_ex=1; downstream stages advance.
REQ-018 Load-use, lowest priority: ex_mem_read & ex_regf_we & ex_rd_s!=0 & (ex_rd_s==id_rs1_s | ex_rd_s==id_rs2_s) -> stall_pc=1, stall_if_id=1, bubble_id_ex=1 for one cycle; the consumer then takes the WB forward path.
REQ-019 Branch and load-use in the same cycle -> branch flush only.
REQ-020 br_taken held under data freeze is acted on in the first cycle after the freeze releases.
REQ-021 stall_cnt +1 in each cycle where stall_pc=1; flush_cnt +1 in each REQ-015 cycle; both wrap modulo 2^32.
REQ-022 Stall, bubble and flush outputs are combinational from state and current inputs; FSM and counters are registered.

Reset
REQ-023 rst=1 -> state RUN, outstanding flags 0, stall_cnt=0, flush_cnt=0.
REQ-024 During rst all stall, bubble, flush and discard outputs = 0.
REQ-025 Responses arriving in the first cycle after reset are ignored; no imem_discard is asserted for them.

Structure
REQ-026 hazard_state_t enum and the priority encoding live in rv32i_types.
REQ-027 A single sub-module hazard_perf_cnt (enable-driven 32-bit wrap counter) is instantiated twice.

Verification
REQ-028 Load-use: lw x5 in EX, add x6,x5,x1 in ID -> 1 cycle with stall_pc=1 and bubble_id_ex=1; with ex_rd_s=0 -> no stall.
REQ-029 dmem_req at cycle 10, dmem_resp at cycle 13 -> all stalls =1 in cycles 10-12, released in cycle 13; stall_cnt +3.
REQ-030 br_taken and load-use together -> flush_if_id=1, bubble_id_ex=1, stall_pc=0; flush_cnt +1.
REQ-031 Fetch outstanding, br_taken, imem_resp two cycles later -> imem_discard=1 on that resp only; state returns to RUN.
REQ-032 br_taken held during a 2-cycle dmem wait -> flush asserted in the cycle after dmem_resp, not before.
REQ-033 rst asserted in D_WAIT -> next cycle state RUN, counters 0, all outputs 0.

Source files
------------

// File: rtl/rv32i_types.sv
// Purpose : shared hazard-control types: FSM state, hazard priority, encode helpers.
// Latency : n/a (types and pure functions only).
// Backpressure: n/a.
package rv32i_types;

    // Memory-side FSM state. I_KILL = fetch outstanding whose data must be dropped.
    typedef enum logic [2:0] {
        RUN     = 3'd0,
        I_WAIT  = 3'd1,
        D_WAIT  = 3'd2,
        ID_WAIT = 3'd3,
        I_KILL  = 3'd4
    } hazard_state_t;

    // Winning hazard for the current cycle, lowest to highest priority.
    typedef enum logic [2:0] {
        PRIO_NONE     = 3'd0,
        PRIO_LOAD_USE = 3'd1,
        PRIO_FETCH    = 3'd2,
        PRIO_BRANCH   = 3'd3,
        PRIO_FREEZE   = 3'd4
    } hazard_prio_t;

    // Data freeze > branch flush > fetch wait > load-use.
    function automatic hazard_prio_t hazard_prio(input logic frz, input logic br,
                                                 input logic fw, input logic lu);
        hazard_prio_t p;
        if (frz)     p = PRIO_FREEZE;
        else if (br) p = PRIO_BRANCH;
        else if (fw) p = PRIO_FETCH;
        else if (lu) p = PRIO_LOAD_USE;
        else         p = PRIO_NONE;
        return p;
    endfunction

    // Outstanding flags to state. A killed fetch alongside a data access
    // reports ID_WAIT; the kill itself is tracked by a separate flag.
    function automatic hazard_state_t hazard_encode(input logic i_out, input logic d_out,
                                                    input logic kill);
        hazard_state_t s;
        if (i_out && d_out) s = ID_WAIT;
        else if (i_out)     s = kill ? I_KILL : I_WAIT;
        else if (d_out)     s = D_WAIT;
        else                s = RUN;
        return s;
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Purpose : 32-bit event counter, +1 per enabled cycle, wraps modulo 2^32.
// Latency : count visible the cycle after the enabled edge.
// Backpressure: none; counts every enabled cycle.
// Ports   : clk, rst (sync active-high), en_i (count enable), cnt_o (count).
module hazard_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst)       cnt_q <= '0;
        else if (en_i) cnt_q <= cnt_q + 32'd1;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose : pipeline hazard control: data freeze, branch flush, fetch wait, load-use.
// Latency : stall/bubble/flush/discard combinational; FSM and counters update on clk.
// Backpressure: freezes all stages while a data access is pending.
// Ports   : ID/EX register ids, branch, imem/dmem req/resp in; stage stalls,
//           bubble/flush, imem_discard and two perf counters out.
module hazard_ctrl
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1_s,
    input  logic [4:0]  id_rs2_s,
    input  logic [4:0]  ex_rd_s,
    input  logic        ex_mem_read,
    input  logic        ex_regf_we,
    input  logic        br_taken,
    input  logic        imem_req,
    input  logic        imem_resp,
    input  logic        dmem_req,
    input  logic        dmem_resp,
    output logic        stall_pc,
    output logic        stall_if_id,
    output logic        stall_id_ex,
    output logic        stall_ex_mem,
    output logic        stall_mem_wb,
    output logic        bubble_id_ex,
    output logic        flush_if_id,
    output logic        imem_discard,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    hazard_state_t state_q, state_d;
    hazard_prio_t  prio;
    logic          kill_q, kill_d;
    logic          frz_q;
    logic          br_pend_q, br_pend_d;
    logic          i_out, d_out, i_next, d_next;
    logic          frz, rel, br_act, fw, lu;
    logic          flush_evt;

    assign i_out = (state_q == I_WAIT) || (state_q == ID_WAIT) || (state_q == I_KILL);
    assign d_out = (state_q == D_WAIT) || (state_q == ID_WAIT);

    assign frz = !dmem_resp && (d_out || dmem_req);
    // Release cycle of a freeze: stages move again, but a held branch waits
    // one more cycle so the redirect sees a settled pipeline.
    assign rel = frz_q && !frz;
    assign br_act = (br_taken || br_pend_q) && !rel;
    assign fw = i_out && !imem_resp;
    assign lu = ex_mem_read && ex_regf_we && (ex_rd_s != 5'd0) &&
                ((ex_rd_s == id_rs1_s) || (ex_rd_s == id_rs2_s));

    assign prio = hazard_prio(frz, br_act, fw, lu);

    always_comb begin
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        stall_mem_wb = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        if (!rst) begin
            case (prio)
                PRIO_FREEZE: begin
                    stall_pc     = 1'b1;
                    stall_if_id  = 1'b1;
                    stall_id_ex  = 1'b1;
                    stall_ex_mem = 1'b1;
                    stall_mem_wb = 1'b1;
                end
                PRIO_BRANCH: begin
                    flush_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                end
                PRIO_FETCH, PRIO_LOAD_USE: begin
                    stall_pc     = 1'b1;
                    stall_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign imem_discard = !rst && kill_q && i_out && imem_resp;
    assign flush_evt    = !rst && (prio == PRIO_BRANCH);

    // A response in the same cycle clears (or never sets) the outstanding flag.
    assign i_next = !imem_resp && (i_out || imem_req);
    assign d_next = !dmem_resp && (d_out || dmem_req);
    assign kill_d = i_next && (kill_q || (flush_evt && i_out));
    // Remember a branch seen while frozen or in the release cycle.
    assign br_pend_d = (frz || frz_q) && (br_pend_q || br_taken);
    assign state_d = hazard_encode(i_next, d_next, kill_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            kill_q    <= 1'b0;
            frz_q     <= 1'b0;
            br_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kill_q    <= kill_d;
            frz_q     <= frz;
            br_pend_q <= br_pend_d;
        end
    end

    hazard_perf_cnt u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (stall_pc),
        .cnt_o (stall_cnt)
    );

    hazard_perf_cnt u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (flush_evt),
        .cnt_o (flush_cnt)
    );

endmodule
